multi_button_event_counter: RTL and testbench
=============================================

// Module: multi_button_event_counter
// PURPOSE
//  Multi-channel push-button test block. Each of CHANNELS raw inputs is synchronised,
//  debounced by a per-channel timer FSM, and edge-detected. Debounced presses and raw
//  (noisy) rising edges are counted side by side. Adds long-press detection and per-channel
//  clear. Sits between board buttons and display or LED logic as a bounce-characterisation aid.
// PARAMETERS
//  CHANNELS     4        number of independent button channels (>=1)
//  BITS         4        width of each count register
//  DB_CYCLES    1000000  stable-input cycles needed to accept a level change (>=2)
//  LONG_CYCLES  50000000 debounced-high cycles before long_press fires (>DB_CYCLES)
//  SATURATE     0        0: counts wrap at 2^BITS-1 -> 0; 1: counts hold at 2^BITS-1
// PORTS
//  clk              in   1              system clock, all logic rising-edge
//  reset_n          in   1              asynchronous, active-low reset
//  button_in        in   CHANNELS       raw asynchronous button levels
//  clear            in   CHANNELS       sync per-channel clear of both counts
//  debounced        out  CHANNELS       debounced level
//  press_tick       out  CHANNELS       1-cycle pulse on debounced 0->1
//  release_tick     out  CHANNELS       1-cycle pulse on debounced 1->0
//  long_press       out  CHANNELS       1-cycle pulse, once per press, after LONG_CYCLES held
//  debounced_count  out  CHANNELS*BITS  channel i at [i*BITS +: BITS]
//  noisy_count      out  CHANNELS*BITS  raw rising-edge count, same packing
// BEHAVIOUR
//  - Reset: all outputs, synchronisers, timers and counts = 0. FSM state = LOW_STABLE.
//    Reset asserted mid-debounce or mid-hold aborts the operation with no pulse.
//  - Sync: 2-FF synchroniser per channel -> s. Noisy edge = s & ~s_d (s_d = s delayed 1 clk).
//  - FSM per channel: LOW_STABLE, LOW_TO_HIGH, HIGH_STABLE, HIGH_TO_LOW.
//    LOW_STABLE: s=1 -> LOW_TO_HIGH, timer=0.
//    LOW_TO_HIGH: s=0 -> LOW_STABLE (bounce rejected). Otherwise timer++.
//      When timer==DB_CYCLES-1 -> HIGH_STABLE, debounced=1, press_tick=1, hold=0.
//    HIGH_STABLE: hold++ until it saturates at LONG_CYCLES. When it reaches LONG_CYCLES,
//      long_press=1 for exactly one cycle. s=0 -> HIGH_TO_LOW, timer=0.
//    HIGH_TO_LOW: mirrors LOW_TO_HIGH. s=1 -> HIGH_STABLE (hold is not reset).
//      When the timer expires -> LOW_STABLE, debounced=0, release_tick=1.
//  - Latency: pad edge to debounced/tick output is 2 (sync) + DB_CYCLES clocks, if stable.
//  - Timer width: $clog2(DB_CYCLES). Hold width: $clog2(LONG_CYCLES+1).
//    Both are registered, and both are unsigned.
//  - Counts: debounced_count[i] increments on press_tick[i]. noisy_count[i] increments on
//    the noisy edge. clear[i] beats an increment in the same cycle (result 0).
//    Wrap or hold at all-ones is set by SATURATE.
//  - Channels are fully independent. Simultaneous events on different channels all count.
// STRUCTURE
//  - Shared package/include: FSM state encodings (2-bit localparams) and a clog2 helper.
//  - Sub-module debounce_channel: sync, FSM, timers, edge pulses and both counters for one
//    channel. Top level = generate loop of CHANNELS instances plus output packing only.
// TESTING  (bench: CHANNELS=2, BITS=3, DB_CYCLES=4, LONG_CYCLES=10)
//  - Reset: hold reset_n=0 with button_in=2'b11 -> all outputs 0. Release -> debounced[1:0]
//    rises 6 clks later, with one press_tick each.
//  - Bounce: ch0 toggles 1,0,1,0,1 at 1-clk spacing, then stays 1 -> noisy_count0=3,
//    debounced_count0=1, a single press_tick.
//  - Long press: ch0 held 20 clks after debounced rise -> exactly one long_press, 10 clks
//    after press_tick. A second press without release never repeats it.
//  - Wrap/saturate: 9 clean presses on ch1 -> count=1 (SATURATE=0), =7 (SATURATE=1).
//  - Clear collision: clear[0] in the same cycle as press_tick[0] -> debounced_count0=0.
//    ch1 counts are unaffected.
//  - Mid-op reset: reset_n pulsed low during LOW_TO_HIGH with timer=2 -> no press_tick.
//    Counts=0 and FSM restarts from LOW_STABLE.

Source files
------------

// File: rtl/multi_button_event_counter_pkg.sv
// Shared state encodings and width helper for the multi-channel button event counter.
package multi_button_event_counter_pkg;

    localparam logic [1:0] ST_LOW_STABLE  = 2'd0;
    localparam logic [1:0] ST_LOW_TO_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH_STABLE = 2'd2;
    localparam logic [1:0] ST_HIGH_TO_LOW = 2'd3;

    // Ceiling log2, floored at 1 so a counter never collapses to zero width.
    function automatic int unsigned clog2_min1(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                width = i + 1;
            end
        end
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/multi_button_event_counter_debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with hold timer, edge pulses
// and the debounced/noisy event counters.
module multi_button_event_counter_debounce_channel
    import multi_button_event_counter_pkg::*;
#(
    parameter int unsigned BITS        = 4,
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned LONG_CYCLES = 50000000,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            button_i,
    input  logic            clear_i,
    output logic            debounced_o,
    output logic            press_tick_o,
    output logic            release_tick_o,
    output logic            long_press_o,
    output logic [BITS-1:0] db_count_o,
    output logic [BITS-1:0] noisy_count_o
);

    localparam int unsigned   TW         = clog2_min1(DB_CYCLES);
    localparam int unsigned   HW         = clog2_min1(LONG_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_CYCLES);

    logic            sync1_q, sync_q, sync_dly_q;
    logic [1:0]      state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic            debounced_q, debounced_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            long_q, long_d;
    logic [BITS-1:0] db_cnt_q, db_cnt_d;
    logic [BITS-1:0] noisy_cnt_q, noisy_cnt_d;
    logic            hold_step;
    logic            noisy_edge;

    function automatic logic [BITS-1:0] bump_count(input logic [BITS-1:0] value);
        if (SATURATE && (value == {BITS{1'b1}})) begin
            return value;
        end
        return value + 1'b1;
    endfunction

    assign noisy_edge = sync_q & ~sync_dly_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        hold_d      = hold_q;
        debounced_d = debounced_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        hold_step   = 1'b0;
        case (state_q)
            ST_LOW_STABLE: begin
                if (sync_q) begin
                    state_d = ST_LOW_TO_HIGH;
                    timer_d = '0;
                end
            end
            ST_LOW_TO_HIGH: begin
                if (!sync_q) begin
                    state_d = ST_LOW_STABLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TIMER_LAST) begin
                        state_d     = ST_HIGH_STABLE;
                        debounced_d = 1'b1;
                        press_d     = 1'b1;
                        hold_d      = '0;
                    end
                end
            end
            ST_HIGH_STABLE: begin
                if (!sync_q) begin
                    state_d = ST_HIGH_TO_LOW;
                    timer_d = '0;
                end else begin
                    hold_step = 1'b1;
                end
            end
            ST_HIGH_TO_LOW: begin
                // A bounce back high keeps the accumulated hold time.
                if (sync_q) begin
                    state_d   = ST_HIGH_STABLE;
                    hold_step = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TIMER_LAST) begin
                        state_d     = ST_LOW_STABLE;
                        debounced_d = 1'b0;
                        release_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOW_STABLE;
            end
        endcase

        // Hold saturates at HOLD_MAX, so long_press fires once per press.
        if (hold_step && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_d == HOLD_MAX);
        end
    end

    always_comb begin
        db_cnt_d    = db_cnt_q;
        noisy_cnt_d = noisy_cnt_q;
        if (clear_i) begin
            db_cnt_d    = '0;
            noisy_cnt_d = '0;
        end else begin
            if (press_q) begin
                db_cnt_d = bump_count(db_cnt_q);
            end
            if (noisy_edge) begin
                noisy_cnt_d = bump_count(noisy_cnt_q);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q     <= 1'b0;
            sync_q      <= 1'b0;
            sync_dly_q  <= 1'b0;
            state_q     <= ST_LOW_STABLE;
            timer_q     <= '0;
            hold_q      <= '0;
            debounced_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            db_cnt_q    <= '0;
            noisy_cnt_q <= '0;
        end else begin
            sync1_q     <= button_i;
            sync_q      <= sync1_q;
            sync_dly_q  <= sync_q;
            state_q     <= state_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
            debounced_q <= debounced_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            db_cnt_q    <= db_cnt_d;
            noisy_cnt_q <= noisy_cnt_d;
        end
    end

    assign debounced_o    = debounced_q;
    assign press_tick_o   = press_q;
    assign release_tick_o = release_q;
    assign long_press_o   = long_q;
    assign db_count_o     = db_cnt_q;
    assign noisy_count_o  = noisy_cnt_q;

endmodule

// File: rtl/multi_button_event_counter.sv
// Multi-channel push-button bounce characterisation block: one independent
// debounce/count channel per button, counts packed channel i at [i*BITS +: BITS].
module multi_button_event_counter
    import multi_button_event_counter_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned BITS        = 4,
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned LONG_CYCLES = 50000000,
    parameter bit          SATURATE    = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [CHANNELS-1:0]      button_in,
    input  logic [CHANNELS-1:0]      clear,
    output logic [CHANNELS-1:0]      debounced,
    output logic [CHANNELS-1:0]      press_tick,
    output logic [CHANNELS-1:0]      release_tick,
    output logic [CHANNELS-1:0]      long_press,
    output logic [CHANNELS*BITS-1:0] debounced_count,
    output logic [CHANNELS*BITS-1:0] noisy_count
);

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_channel
            multi_button_event_counter_debounce_channel #(
                .BITS        (BITS),
                .DB_CYCLES   (DB_CYCLES),
                .LONG_CYCLES (LONG_CYCLES),
                .SATURATE    (SATURATE)
            ) u_channel (
                .clk_i          (clk),
                .rst_ni         (reset_n),
                .button_i       (button_in[gi]),
                .clear_i        (clear[gi]),
                .debounced_o    (debounced[gi]),
                .press_tick_o   (press_tick[gi]),
                .release_tick_o (release_tick[gi]),
                .long_press_o   (long_press[gi]),
                .db_count_o     (debounced_count[gi*BITS +: BITS]),
                .noisy_count_o  (noisy_count[gi*BITS +: BITS])
            );
        end
    endgenerate

endmodule

// File: tb/tb_multi_button_event_counter.sv
// Bench for multi_button_event_counter: directed scenarios plus random button noise,
// every cycle compared against a behavioural "N consecutive differing samples" model.
module tb_multi_button_event_counter;

    localparam int CH   = 2;
    localparam int BITS = 3;
    localparam int DB   = 4;
    localparam int LONG = 10;
    localparam bit SAT  = 1'b0;
    localparam int CMAX = (1 << BITS) - 1;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [CH-1:0]      button_in = '0;
    logic [CH-1:0]      clear = '0;
    logic [CH-1:0]      debounced, press_tick, release_tick, long_press;
    logic [CH*BITS-1:0] debounced_count, noisy_count;

    multi_button_event_counter #(
        .CHANNELS    (CH),
        .BITS        (BITS),
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG),
        .SATURATE    (SAT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .button_in       (button_in),
        .clear           (clear),
        .debounced       (debounced),
        .press_tick      (press_tick),
        .release_tick    (release_tick),
        .long_press      (long_press),
        .debounced_count (debounced_count),
        .noisy_count     (noisy_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: pad delay line, consecutive-differing-sample run,
    // accepted level, hold time, pulses and counts.
    int m_p1[CH], m_s[CH], m_sd[CH], m_run[CH], m_deb[CH], m_hold[CH];
    int m_press[CH], m_rel[CH], m_long[CH], m_dcnt[CH], m_ncnt[CH];
    int obs_press[CH], obs_long[CH];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bump(input int v);
        if (SAT) return (v >= CMAX) ? CMAX : v + 1;
        return (v + 1) % (CMAX + 1);
    endfunction

    task automatic model_step();
        for (int c = 0; c < CH; c++) begin
            bit noisy_rise, press_seen;
            noisy_rise = (m_s[c] == 1) && (m_sd[c] == 0);
            press_seen = (m_press[c] == 1);
            if (!reset_n) begin
                m_p1[c] = 0; m_s[c] = 0; m_sd[c] = 0; m_run[c] = 0; m_deb[c] = 0;
                m_hold[c] = 0; m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0;
                m_dcnt[c] = 0; m_ncnt[c] = 0;
            end else begin
                if (clear[c]) begin
                    m_dcnt[c] = 0;
                    m_ncnt[c] = 0;
                end else begin
                    if (press_seen) m_dcnt[c] = bump(m_dcnt[c]);
                    if (noisy_rise) m_ncnt[c] = bump(m_ncnt[c]);
                end
                m_press[c] = 0; m_rel[c] = 0; m_long[c] = 0;
                if (m_deb[c] == 1 && m_s[c] == 1 && m_hold[c] < LONG) begin
                    m_hold[c]++;
                    if (m_hold[c] == LONG) m_long[c] = 1;
                end
                if (m_s[c] != m_deb[c]) begin
                    m_run[c]++;
                    if (m_run[c] == DB) begin
                        m_run[c] = 0;
                        m_deb[c] = m_s[c];
                        if (m_deb[c] == 1) begin
                            m_press[c] = 1;
                            m_hold[c]  = 0;
                        end else begin
                            m_rel[c] = 1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_sd[c] = m_s[c];
                m_s[c]  = m_p1[c];
                m_p1[c] = int'(button_in[c]);
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < CH; c++) begin
            check_value($sformatf("debounced[%0d]", c), 32'(debounced[c]), 32'(m_deb[c]));
            check_value($sformatf("press_tick[%0d]", c), 32'(press_tick[c]), 32'(m_press[c]));
            check_value($sformatf("release_tick[%0d]", c), 32'(release_tick[c]), 32'(m_rel[c]));
            check_value($sformatf("long_press[%0d]", c), 32'(long_press[c]), 32'(m_long[c]));
            check_value($sformatf("debounced_count[%0d]", c),
                        32'(debounced_count[c*BITS +: BITS]), 32'(m_dcnt[c]));
            check_value($sformatf("noisy_count[%0d]", c),
                        32'(noisy_count[c*BITS +: BITS]), 32'(m_ncnt[c]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        for (int c = 0; c < CH; c++) begin
            obs_press[c] += int'(press_tick[c]);
            obs_long[c]  += int'(long_press[c]);
        end
    endtask

    task automatic run_ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clear_obs();
        for (int c = 0; c < CH; c++) begin
            obs_press[c] = 0;
            obs_long[c]  = 0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat[CH];
        int p_at, l_at, exp_wrap;
        int v_seq[5];

        // ---- Reset with both buttons held ----
        reset_n   = 1'b0;
        button_in = 2'b11;
        run_ticks(3);
        check_value("reset_debounced", 32'(debounced), 0);
        check_value("reset_pulses", 32'(press_tick | release_tick | long_press), 0);
        check_value("reset_db_count", 32'(debounced_count), 0);
        check_value("reset_noisy_count", 32'(noisy_count), 0);
        reset_n = 1'b1;
        clear_obs();
        lat = '{0, 0};
        for (int k = 1; k <= 12; k++) begin
            tick();
            for (int c = 0; c < CH; c++) if (debounced[c] && lat[c] == 0) lat[c] = k;
        end
        for (int c = 0; c < CH; c++) begin
            check_value($sformatf("reset_latency[%0d]", c), 32'(lat[c]), 32'(2 + DB));
            check_value($sformatf("reset_press_ticks[%0d]", c), 32'(obs_press[c]), 1);
        end

        // ---- Bounce rejection on ch0 ----
        button_in = 2'b00;
        run_ticks(DB + 4);
        clear = 2'b11;
        tick();
        clear = 2'b00;
        clear_obs();
        v_seq = '{1, 0, 1, 0, 1};
        foreach (v_seq[i]) begin
            button_in[0] = v_seq[i][0];
            tick();
        end
        run_ticks(DB + 4);
        check_value("bounce_press_ticks", 32'(obs_press[0]), 1);
        check_value("bounce_noisy_count0", 32'(noisy_count[0 +: BITS]), 3);
        check_value("bounce_db_count0", 32'(debounced_count[0 +: BITS]), 1);

        // ---- Long press, then a sub-debounce dip that must not retrigger it ----
        button_in[0] = 1'b0;
        run_ticks(DB + 4);
        clear_obs();
        button_in[0] = 1'b1;
        p_at = -1;
        l_at = -1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (press_tick[0] && p_at < 0) p_at = k;
            if (long_press[0]) l_at = k;
            if (p_at > 0 && k == p_at + 20) break;
        end
        check_value("long_press_count", 32'(obs_long[0]), 1);
        check_value("long_press_delay", 32'(l_at - p_at), 32'(LONG));
        button_in[0] = 1'b0;
        run_ticks(2);
        button_in[0] = 1'b1;
        run_ticks(20);
        check_value("long_press_no_repeat", 32'(obs_long[0]), 1);
        check_value("long_press_single_press", 32'(obs_press[0]), 1);

        // ---- Wrap / saturate on ch1 with nine clean presses ----
        button_in = 2'b00;
        run_ticks(DB + 4);
        clear = 2'b10;
        tick();
        clear = 2'b00;
        clear_obs();
        for (int p = 0; p < 9; p++) begin
            button_in[1] = 1'b1;
            run_ticks(DB + 4);
            button_in[1] = 1'b0;
            run_ticks(DB + 4);
        end
        exp_wrap = SAT ? CMAX : (9 % (CMAX + 1));
        check_value("wrap_press_ticks", 32'(obs_press[1]), 9);
        check_value("wrap_db_count1", 32'(debounced_count[BITS +: BITS]), 32'(exp_wrap));
        check_value("wrap_noisy_count1", 32'(noisy_count[BITS +: BITS]), 32'(exp_wrap));

        // ---- Clear colliding with press_tick on ch0 ----
        button_in[0] = 1'b1;
        p_at = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (press_tick[0]) begin
                p_at = k;
                break;
            end
        end
        check_value("collision_press_seen", 32'(p_at), 32'(2 + DB));
        clear = 2'b01;
        tick();
        clear = 2'b00;
        run_ticks(3);
        check_value("collision_db_count0", 32'(debounced_count[0 +: BITS]), 0);
        check_value("collision_noisy_count0", 32'(noisy_count[0 +: BITS]), 0);
        check_value("collision_db_count1", 32'(debounced_count[BITS +: BITS]), 32'(exp_wrap));
        check_value("collision_noisy_count1", 32'(noisy_count[BITS +: BITS]), 32'(exp_wrap));

        // ---- Reset pulse during LOW_TO_HIGH (timer at 2) ----
        button_in = 2'b00;
        run_ticks(DB + 4);
        button_in[0] = 1'b1;
        clear_obs();
        run_ticks(5);
        reset_n = 1'b0;
        #1;
        check_value("midreset_debounced", 32'(debounced), 0);
        check_value("midreset_counts", 32'({debounced_count, noisy_count}), 0);
        tick();
        reset_n = 1'b1;
        p_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (press_tick[0] && p_at < 0) p_at = k;
        end
        check_value("midreset_restart_latency", 32'(p_at), 32'(2 + DB));
        check_value("midreset_press_ticks", 32'(obs_press[0]), 1);

        // ---- Random noise with clears and occasional resets ----
        for (int blk = 0; blk < 15; blk++) begin
            int unsigned rate;
            rate = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 8 : 40);
            for (int i = 0; i < 200; i++) begin
                for (int c = 0; c < CH; c++) begin
                    if ($urandom_range(rate - 1) == 0) button_in[c] = ~button_in[c];
                    clear[c] = ($urandom_range(63) == 0);
                end
                reset_n = ($urandom_range(999) != 0);
                tick();
            end
        end
        reset_n = 1'b1;
        clear   = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
